// File: rtl/pixel_packer_if.sv
// pixel_packer_if: frame control, pixel input and packed-byte output bundle
interface pixel_packer_if;
   logic        start;
   logic [11:0] size_x;
   logic [11:0] size_y;
   logic        pixel_in;
   logic        pixel_valid;
   logic [7:0]  byte_out;
   logic        byte_valid;
   logic        byte_ready;
   logic        eol;
   logic        eof;
   logic        busy;
   logic        done;
   logic        overflow;
   modport master (
      output start, size_x, size_y, pixel_in, pixel_valid, byte_ready,
      input  byte_out, byte_valid, eol, eof, busy, done, overflow
   );
   modport slave (
      input  start, size_x, size_y, pixel_in, pixel_valid, byte_ready,
      output byte_out, byte_valid, eol, eof, busy, done, overflow
   );
endinterface

// File: rtl/pixel_packer.sv
// pixel_packer: packs 1-bit pixels LSB-first into bytes with line/frame markers through a 4-deep FIFO
module pixel_packer (
   input logic          clk,
   input logic          rst,
   pixel_packer_if.slave bus
);
   typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;
   state_t      state_q, state_d;
   logic [11:0] sx_q, sy_q, x_q, y_q;
   logic [7:0]  sh_q, sh_nx;
   logic        ovf_q;
   logic [9:0]  mem_q [4];
   logic [1:0]  rd_q, wr_q;
   logic [2:0]  cnt_q;
   logic        accept, px, eol_hit, eof_hit, push, full, empty, pop, wr_en, drop;
   assign accept  = state_q == IDLE && bus.start && bus.size_x != 12'd0 && bus.size_y != 12'd0;
   assign px      = state_q == COLLECT && bus.pixel_valid;
   assign eol_hit = x_q == sx_q - 12'd1;
   assign eof_hit = eol_hit && y_q == sy_q - 12'd1;
   assign sh_nx   = sh_q | (8'(bus.pixel_in) << x_q[2:0]);
   assign push    = px && (x_q[2:0] == 3'd7 || eol_hit);
   assign empty   = cnt_q == 3'd0;
   assign full    = cnt_q == 3'd4;
   assign pop     = !empty && bus.byte_ready;
   assign wr_en   = push && (!full || pop);
   assign drop    = push && full && !pop;
   assign bus.byte_valid = !empty;
   assign bus.overflow   = ovf_q;
   assign {bus.eof, bus.eol, bus.byte_out} = empty ? 10'd0 : mem_q[rd_q];
   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end
   // next state, busy and the end-of-drain done pulse
   always_comb begin
      state_d  = state_q;
      bus.busy = state_q != IDLE;
      bus.done = 1'b0;
      if (accept) state_d = COLLECT;
      if (push && eof_hit) state_d = DRAIN;
      if (state_q == DRAIN && empty) begin
         state_d  = IDLE;
         bus.done = 1'b1;
      end
   end
   // frame geometry, x/y counters, shift byte and sticky overflow
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sx_q  <= '0;
         sy_q  <= '0;
         x_q   <= '0;
         y_q   <= '0;
         sh_q  <= '0;
         ovf_q <= 1'b0;
      end else if (accept) begin
         sx_q  <= bus.size_x;
         sy_q  <= bus.size_y;
         x_q   <= '0;
         y_q   <= '0;
         sh_q  <= '0;
         ovf_q <= 1'b0;
      end else if (px) begin
         x_q   <= eol_hit ? 12'd0 : x_q + 12'd1;
         y_q   <= eof_hit ? 12'd0 : (eol_hit ? y_q + 12'd1 : y_q);
         sh_q  <= push ? 8'd0 : sh_nx;
         ovf_q <= ovf_q | drop;
      end
   end
   // FIFO of {eof, eol, byte}; a full push is only taken alongside a pop
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 4; i++) mem_q[i] <= '0;
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (wr_en) begin
            mem_q[wr_q] <= {eof_hit, eol_hit, sh_nx};
            wr_q        <= wr_q + 2'd1;
         end
         if (pop) rd_q <= rd_q + 2'd1;
         cnt_q <= cnt_q + 3'(wr_en) - 3'(pop);
      end
   end
endmodule

// File: tb/tb_pixel_packer.sv
// tb_pixel_packer: directed scenario tests for pixel_packer
module tb_pixel_packer;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   int         errors = 0;
   int         checks = 0;
   int         done_cnt = 0;
   logic [9:0] q[$];
   pixel_packer_if ifc();
   pixel_packer dut (.clk(clk), .rst(rst), .bus(ifc.slave));
   always #5 clk = ~clk;
   // record every transfer as {eof, eol, byte} and count done pulses
   always @(negedge clk) begin
      if (rst) begin
         if (ifc.byte_valid && ifc.byte_ready) q.push_back({ifc.eof, ifc.eol, ifc.byte_out});
         if (ifc.done) done_cnt++;
      end
   end
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask
   task automatic start_frame(input logic [11:0] sx, input logic [11:0] sy);
      ifc.size_x = sx;
      ifc.size_y = sy;
      ifc.start  = 1'b1;
      cyc();
      ifc.start  = 1'b0;
   endtask
   task automatic feed(input int n, input logic [63:0] pat);
      for (int i = 0; i < n; i++) begin
         ifc.pixel_valid = 1'b1;
         ifc.pixel_in    = pat[i];
         cyc();
      end
      ifc.pixel_valid = 1'b0;
   endtask
   task automatic wait_idle();
      for (int i = 0; i < 100 && ifc.busy; i++) cyc();
   endtask
   task automatic clear();
      q.delete();
      done_cnt = 0;
   endtask
   task automatic test_reset();
      cyc();
      cyc();
      checks++; if (ifc.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", ifc.busy); end
      checks++; if (ifc.byte_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", ifc.byte_valid); end
      checks++; if ({ifc.eof, ifc.eol, ifc.byte_out} !== 10'h000) begin errors++; $display("FAIL reset_head got=%h exp=000", {ifc.eof, ifc.eol, ifc.byte_out}); end
      checks++; if ({ifc.done, ifc.overflow} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b exp=00", {ifc.done, ifc.overflow}); end
      rst = 1'b1;
      cyc();
   endtask
   task automatic test_basic();
      clear();
      ifc.byte_ready = 1'b1;
      start_frame(12'd8, 12'd2);
      feed(8, '1);
      checks++; if ({ifc.byte_valid, ifc.eof, ifc.eol, ifc.byte_out} !== 11'h5FF) begin errors++; $display("FAIL basic_latency got=%h exp=5ff", {ifc.byte_valid, ifc.eof, ifc.eol, ifc.byte_out}); end
      ifc.start  = 1'b1;
      ifc.size_x = 12'd3;
      ifc.size_y = 12'd3;
      feed(8, '1);
      ifc.start = 1'b0;
      feed(1, '1);
      wait_idle();
      checks++; if (ifc.busy !== 1'b0) begin errors++; $display("FAIL basic_busy got=%0b exp=0", ifc.busy); end
      checks++; if (q.size() !== 2) begin errors++; $display("FAIL basic_count got=%0d exp=2", q.size()); end
      checks++; if (q[0] !== 10'h1FF) begin errors++; $display("FAIL basic_byte0 got=%h exp=1ff", q[0]); end
      checks++; if (q[1] !== 10'h3FF) begin errors++; $display("FAIL basic_byte1 got=%h exp=3ff", q[1]); end
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL basic_done got=%0d exp=1", done_cnt); end
   endtask
   task automatic test_pattern();
      clear();
      start_frame(12'd10, 12'd1);
      feed(10, 64'h155);
      wait_idle();
      checks++; if (q.size() !== 2) begin errors++; $display("FAIL pattern_count got=%0d exp=2", q.size()); end
      checks++; if (q[0] !== 10'h055) begin errors++; $display("FAIL pattern_byte0 got=%h exp=055", q[0]); end
      checks++; if (q[1] !== 10'h301) begin errors++; $display("FAIL pattern_byte1 got=%h exp=301", q[1]); end
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL pattern_done got=%0d exp=1", done_cnt); end
   endtask
   task automatic test_overflow();
      clear();
      ifc.byte_ready = 1'b0;
      start_frame(12'd40, 12'd1);
      feed(40, '1);
      checks++; if (ifc.overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%0b exp=1", ifc.overflow); end
      checks++; if (ifc.busy !== 1'b1) begin errors++; $display("FAIL ovf_busy got=%0b exp=1", ifc.busy); end
      cyc();
      cyc();
      cyc();
      checks++; if ({ifc.byte_valid, ifc.eof, ifc.eol, ifc.byte_out} !== 11'h4FF) begin errors++; $display("FAIL ovf_hold got=%h exp=4ff", {ifc.byte_valid, ifc.eof, ifc.eol, ifc.byte_out}); end
      checks++; if (q.size() !== 0) begin errors++; $display("FAIL ovf_stall got=%0d exp=0", q.size()); end
      ifc.byte_ready = 1'b1;
      wait_idle();
      checks++; if (q.size() !== 4) begin errors++; $display("FAIL ovf_count got=%0d exp=4", q.size()); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (q[i] !== 10'h0FF) begin errors++; $display("FAIL ovf_byte%0d got=%h exp=0ff", i, q[i]); end
      end
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL ovf_done got=%0d exp=1", done_cnt); end
      checks++; if (ifc.overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%0b exp=1", ifc.overflow); end
   endtask
   task automatic test_back_to_back();
      clear();
      ifc.byte_ready = 1'b0;
      start_frame(12'd40, 12'd1);
      checks++; if (ifc.overflow !== 1'b0) begin errors++; $display("FAIL b2b_ovf_clear got=%0b exp=0", ifc.overflow); end
      feed(39, '1);
      ifc.byte_ready = 1'b1;
      feed(1, '1);
      checks++; if (ifc.overflow !== 1'b0) begin errors++; $display("FAIL b2b_ovf got=%0b exp=0", ifc.overflow); end
      wait_idle();
      checks++; if (q.size() !== 5) begin errors++; $display("FAIL b2b_count got=%0d exp=5", q.size()); end
      checks++; if (q[0] !== 10'h0FF) begin errors++; $display("FAIL b2b_byte0 got=%h exp=0ff", q[0]); end
      checks++; if (q[4] !== 10'h3FF) begin errors++; $display("FAIL b2b_byte4 got=%h exp=3ff", q[4]); end
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL b2b_done got=%0d exp=1", done_cnt); end
   endtask
   task automatic test_mid_reset();
      clear();
      ifc.byte_ready = 1'b0;
      start_frame(12'd40, 12'd1);
      feed(24, '1);
      checks++; if (ifc.byte_valid !== 1'b1) begin errors++; $display("FAIL mrst_buffered got=%0b exp=1", ifc.byte_valid); end
      #2;
      rst = 1'b0;
      #1;
      checks++; if ({ifc.byte_valid, ifc.busy, ifc.done, ifc.overflow} !== 4'b0000) begin errors++; $display("FAIL mrst_flags got=%b exp=0000", {ifc.byte_valid, ifc.busy, ifc.done, ifc.overflow}); end
      checks++; if ({ifc.eof, ifc.eol, ifc.byte_out} !== 10'h000) begin errors++; $display("FAIL mrst_head got=%h exp=000", {ifc.eof, ifc.eol, ifc.byte_out}); end
      @(posedge clk);
      #1;
      rst = 1'b1;
      cyc();
      clear();
      ifc.byte_ready = 1'b1;
      start_frame(12'd8, 12'd1);
      feed(8, 64'h3C);
      wait_idle();
      checks++; if (q.size() !== 1) begin errors++; $display("FAIL mrst_count got=%0d exp=1", q.size()); end
      checks++; if (q[0] !== 10'h33C) begin errors++; $display("FAIL mrst_byte got=%h exp=33c", q[0]); end
   endtask
   task automatic test_zero_size();
      clear();
      start_frame(12'd0, 12'd5);
      checks++; if (ifc.busy !== 1'b0) begin errors++; $display("FAIL zero_x_busy got=%0b exp=0", ifc.busy); end
      start_frame(12'd7, 12'd0);
      checks++; if (ifc.busy !== 1'b0) begin errors++; $display("FAIL zero_y_busy got=%0b exp=0", ifc.busy); end
      feed(8, '1);
      cyc();
      checks++; if (q.size() !== 0) begin errors++; $display("FAIL zero_bytes got=%0d exp=0", q.size()); end
      checks++; if (ifc.byte_valid !== 1'b0) begin errors++; $display("FAIL zero_valid got=%0b exp=0", ifc.byte_valid); end
   endtask
   initial begin
      ifc.start       = 1'b0;
      ifc.size_x      = '0;
      ifc.size_y      = '0;
      ifc.pixel_in    = 1'b0;
      ifc.pixel_valid = 1'b0;
      ifc.byte_ready  = 1'b0;
      test_reset();
      test_basic();
      test_pattern();
      test_overflow();
      test_back_to_back();
      test_mid_reset();
      test_zero_size();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/pixel_packer.md
PIXEL_PACKER -- requirements
Module: pixel_packer

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-low reset (asserted when 0).
REQ-003 start  input  1  one-cycle frame-start pulse; latches size_x/size_y.
REQ-004 size_x  input  12  pixels per line, unsigned.
REQ-005 size_y  input  12  lines per frame, unsigned.
REQ-006 pixel_in  input  1  pixel data from the upstream engine (its pixel_out).
REQ-007 pixel_valid  input  1  pixel_in is valid this cycle.
REQ-008 byte_out  output  8  packed pixel byte at the FIFO head.
REQ-009 byte_valid  output  1  byte_out/eol/eof are valid.
REQ-010 byte_ready  input  1  downstream accepts; a transfer happens when byte_valid and byte_ready are both 1.
REQ-011 eol  output  1  the head byte is the last byte of a line.
REQ-012 eof  output  1  the head byte is the last byte of the frame.
REQ-013 busy  output  1  state is not IDLE.
REQ-014 done  output  1  one-cycle pulse when the frame is fully drained.
REQ-015 overflow  output  1  sticky flag: a byte was dropped because the FIFO was full.

Function
REQ-016 State machine: IDLE, COLLECT, DRAIN; the block SHALL be in IDLE after reset.
REQ-017 IDLE: on start with size_x!=0 and size_y!=0, latch both sizes, clear x/y counters, clear overflow, go to COLLECT.
REQ-018 IDLE: start with size_x==0 or size_y==0 is ignored; state stays IDLE and busy stays 0.
REQ-019 start in COLLECT or DRAIN is ignored.
REQ-020 pixel_valid is ignored in IDLE and DRAIN.
REQ-021 COLLECT: each valid pixel goes into bit position (x mod 8) of the shift byte, LSB first; x increments by 1.
REQ-022 A byte is pushed when 8 bits are filled, or when x==size_x-1 (end of line).
REQ-023 An end-of-line push zero-pads the unused high bits and sets eol=1.
REQ-024 At end of line: x returns to 0 and y increments by 1.
REQ-025 If y==size_y-1 at end of line, the push also sets eof=1 and the state goes to DRAIN.
REQ-026 Latency: a pixel that completes a byte on cycle N makes that byte visible at the head (byte_valid=1) on cycle N+1, provided the FIFO was empty.
REQ-027 FIFO: 4 entries of {eof, eol, byte}, first-in first-out.
  - The head drives byte_out, eol and eof.
  - byte_valid = not empty.
REQ-028 Push while full with no pop: the byte is dropped, overflow is set to 1, and FIFO contents are unchanged.
  - Counters still advance.
  - overflow stays 1 until the next accepted start or reset.
REQ-029 Push while full with a simultaneous pop: both happen, occupancy stays 4, and no overflow.
REQ-030 Push and pop on the same cycle while non-full: both happen and occupancy is unchanged.
REQ-031 byte_out, eol and eof SHALL stay stable while byte_valid=1 and byte_ready=0.
REQ-032 DRAIN: when the FIFO becomes empty, pulse done for one cycle and go to IDLE.
REQ-033 Counters are 12 bits wide; x and y never exceed size-1, so no wrap-around occurs.

Reset
REQ-034 While rst=0, asynchronously and regardless of state:
  - state=IDLE
  - FIFO emptied
  - x, y and the shift byte cleared
  - byte_out=0, byte_valid=0, eol=0, eof=0, busy=0, done=0, overflow=0
REQ-035 Reset asserted mid-frame discards all partial and buffered data.
  - After release the block waits in IDLE for a new start.

Verification
REQ-036 size 8x2, 16 pixels of 1, byte_ready=1 -> bytes 0xFF(eol), then 0xFF(eol, eof); done pulses once; busy=0 afterwards.
REQ-037 size 10x1, pixels 1,0,1,0,... -> 0x55 (eol=0), then 0x01 (eol=1, eof=1).
REQ-038 size 40x1, all 1, byte_ready=0 -> 4 bytes of 0xFF held in the FIFO; 5th byte dropped; overflow=1.
  - Then raise byte_ready -> exactly 4 transfers, then done.
REQ-039 rst=0 mid-COLLECT, 3 bytes buffered -> all outputs 0 immediately.
  - Then a new 8x1 frame produces a single byte with no stale data.
REQ-040 start with size_x=0 -> busy=0 and no bytes.
  - start and pixel_valid during a running frame -> ignored; outputs match REQ-036.
